// File: rtl/crossing_pkg.sv
// Shared state codes, lamp patterns and lamp bit positions for the crossing controller.
package crossing_pkg;

   typedef enum logic [2:0] {
      ST_RGREEN   = 3'd0,
      ST_AMBER    = 3'd1,
      ST_ALLRED   = 3'd2,
      ST_WALK     = 3'd3,
      ST_FLASH    = 3'd4,
      ST_REDAMBER = 3'd5
   } state_e;

   localparam int unsigned LAMP_ROAD_RED   = 4;
   localparam int unsigned LAMP_ROAD_AMBER = 3;
   localparam int unsigned LAMP_ROAD_GREEN = 2;
   localparam int unsigned LAMP_CROSS_STOP = 1;
   localparam int unsigned LAMP_CROSS_GO   = 0;

   localparam logic [4:0] LS_RGREEN   = 5'b00110;
   localparam logic [4:0] LS_AMBER    = 5'b01010;
   localparam logic [4:0] LS_ALLRED   = 5'b10010;
   localparam logic [4:0] LS_WALK     = 5'b10001;
   localparam logic [4:0] LS_FLASH    = 5'b10001;
   localparam logic [4:0] LS_REDAMBER = 5'b11010;

endpackage

// File: rtl/phase_timer.sv
// Generic phase down-counter: load on demand, otherwise decrement and hold at zero.
module phase_timer #(
   parameter int               CNT_W   = 8,
   parameter logic [CNT_W-1:0] RST_VAL = {CNT_W{1'b0}}
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic [CNT_W-1:0] count_d_o,
   output logic             zero_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // next count: load wins, else saturating decrement
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (count_q != {CNT_W{1'b0}}) begin
         count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         count_d = count_q;
      end
   end

   // counter register
   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= RST_VAL;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_d_o = count_d;
   assign zero_o    = (count_q == {CNT_W{1'b0}});

endmodule

// File: rtl/crossing_controller.sv
// Timed-phase pedestrian/cyclist crossing controller with latched request and WAIT lamp.
// Define CROSS_FLASH_EN to make the go lamp blink during the FLASH phase.
module crossing_controller
   import crossing_pkg::*;
#(
   parameter int NREQ        = 2,
   parameter int CNT_W       = 8,
   parameter int T_GREEN_MIN = 8,
   parameter int T_AMBER     = 3,
   parameter int T_ALLRED    = 2,
   parameter int T_WALK      = 6,
   parameter int T_FLASH     = 4,
   parameter int T_REDAMBER  = 2
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [NREQ-1:0] start,
   output logic [4:0]      lightseq,
   output logic            wait_lamp,
   output logic [2:0]      phase
);

   localparam logic [CNT_W-1:0] LD_GREEN    = CNT_W'(T_GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] LD_AMBER    = CNT_W'(T_AMBER - 1);
   localparam logic [CNT_W-1:0] LD_ALLRED   = CNT_W'(T_ALLRED - 1);
   localparam logic [CNT_W-1:0] LD_WALK     = CNT_W'(T_WALK - 1);
   localparam logic [CNT_W-1:0] LD_FLASH    = CNT_W'(T_FLASH - 1);
   localparam logic [CNT_W-1:0] LD_REDAMBER = CNT_W'(T_REDAMBER - 1);

   state_e           state_q;
   state_e           state_d;
   logic             pending_q;
   logic             pending_d;
   logic [4:0]       lightseq_q;
   logic [4:0]       lightseq_d;
   logic             load_s;
   logic [CNT_W-1:0] load_val_s;
   logic [CNT_W-1:0] cnt_next_s;
   logic             zero_s;
   logic             req_s;
   logic             unused_cnt_s;

   assign req_s = |start;

   phase_timer #(
      .CNT_W   (CNT_W),
      .RST_VAL (LD_GREEN)
   ) u_timer (
      .clock      (clock),
      .reset      (reset),
      .load_i     (load_s),
      .load_val_i (load_val_s),
      .count_d_o  (cnt_next_s),
      .zero_o     (zero_s)
   );

   // phase sequencing; every state entry reloads the timer with that phase's length
   always_comb begin
      state_d    = state_q;
      load_s     = 1'b0;
      load_val_s = LD_GREEN;
      case (state_q)
         ST_RGREEN: begin
            if (zero_s && (pending_q || req_s)) begin
               state_d    = ST_AMBER;
               load_s     = 1'b1;
               load_val_s = LD_AMBER;
            end else begin
               state_d = ST_RGREEN;
            end
         end
         ST_AMBER: begin
            if (zero_s) begin
               state_d    = ST_ALLRED;
               load_s     = 1'b1;
               load_val_s = LD_ALLRED;
            end else begin
               state_d = ST_AMBER;
            end
         end
         ST_ALLRED: begin
            if (zero_s) begin
               state_d    = ST_WALK;
               load_s     = 1'b1;
               load_val_s = LD_WALK;
            end else begin
               state_d = ST_ALLRED;
            end
         end
         ST_WALK: begin
            if (zero_s) begin
               state_d    = ST_FLASH;
               load_s     = 1'b1;
               load_val_s = LD_FLASH;
            end else begin
               state_d = ST_WALK;
            end
         end
         ST_FLASH: begin
            if (zero_s) begin
               state_d    = ST_REDAMBER;
               load_s     = 1'b1;
               load_val_s = LD_REDAMBER;
            end else begin
               state_d = ST_FLASH;
            end
         end
         ST_REDAMBER: begin
            if (zero_s) begin
               state_d    = ST_RGREEN;
               load_s     = 1'b1;
               load_val_s = LD_GREEN;
            end else begin
               state_d = ST_REDAMBER;
            end
         end
         default: begin
            state_d    = ST_RGREEN;
            load_s     = 1'b1;
            load_val_s = LD_GREEN;
         end
      endcase
   end

   // a press in the cycle that enters WALK is already being served
   always_comb begin
      if ((state_d == ST_WALK) && (state_q != ST_WALK)) begin
         pending_d = 1'b0;
      end else if (req_s) begin
         pending_d = 1'b1;
      end else begin
         pending_d = pending_q;
      end
   end

   // lamp pattern for the upcoming state, registered so the lamps change with the phase
   always_comb begin
      lightseq_d = LS_ALLRED;
      case (state_d)
         ST_RGREEN:   lightseq_d = LS_RGREEN;
         ST_AMBER:    lightseq_d = LS_AMBER;
         ST_ALLRED:   lightseq_d = LS_ALLRED;
         ST_WALK:     lightseq_d = LS_WALK;
         ST_FLASH: begin
            lightseq_d = LS_FLASH;
`ifdef CROSS_FLASH_EN
            lightseq_d[LAMP_CROSS_GO]   = cnt_next_s[0];
            lightseq_d[LAMP_CROSS_STOP] = 1'b0;
`endif
         end
         ST_REDAMBER: lightseq_d = LS_REDAMBER;
         default:     lightseq_d = LS_ALLRED;
      endcase
   end

`ifdef CROSS_FLASH_EN
   assign unused_cnt_s = ^cnt_next_s[CNT_W-1:1];
`else
   assign unused_cnt_s = ^cnt_next_s;
`endif

   // state, request flag and lamp registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_RGREEN;
         pending_q  <= 1'b0;
         lightseq_q <= LS_RGREEN;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         lightseq_q <= lightseq_d;
      end
   end

   assign lightseq  = lightseq_q;
   assign wait_lamp = pending_q;
   assign phase     = state_q;

endmodule

// File: tb/tb_crossing_controller.sv
// Scoreboard bench: driver pushes model predictions, monitor pops and compares each cycle.
module tb_crossing_controller;

   localparam int NREQ        = 2;
   localparam int CNT_W       = 8;
   localparam int T_GREEN_MIN = 8;
   localparam int T_AMBER     = 3;
   localparam int T_ALLRED    = 2;
   localparam int T_WALK      = 6;
   localparam int T_FLASH     = 4;
   localparam int T_REDAMBER  = 2;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [NREQ-1:0] start = '0;
   logic [4:0]      lightseq;
   logic            wait_lamp;
   logic [2:0]      phase;

   crossing_controller #(
      .NREQ(NREQ), .CNT_W(CNT_W), .T_GREEN_MIN(T_GREEN_MIN), .T_AMBER(T_AMBER),
      .T_ALLRED(T_ALLRED), .T_WALK(T_WALK), .T_FLASH(T_FLASH), .T_REDAMBER(T_REDAMBER)
   ) dut (
      .clock(clock), .reset(reset), .start(start),
      .lightseq(lightseq), .wait_lamp(wait_lamp), .phase(phase)
   );

   always #5 clock = ~clock;

   // expected {phase, lightseq, wait_lamp}
   logic [8:0] exp_q[$];
   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   // reference model: phase index, cycles spent in it so far, request flag
   int m_ph = 0;
   int m_t = 0;
   bit m_pend = 1'b0;

   function automatic int dur(input int ph);
      case (ph)
         0: return T_GREEN_MIN;
         1: return T_AMBER;
         2: return T_ALLRED;
         3: return T_WALK;
         4: return T_FLASH;
         default: return T_REDAMBER;
      endcase
   endfunction

   function automatic logic [4:0] lamps(input int ph, input int t);
      logic [4:0] l;
      case (ph)
         0: l = 5'b00110;
         1: l = 5'b01010;
         2: l = 5'b10010;
         3: l = 5'b10001;
         4: begin
            l = 5'b10001;
`ifdef CROSS_FLASH_EN
            // remaining cycles odd -> lamp on, ending off
            l = (((T_FLASH - 1 - t) % 2) == 1) ? 5'b10001 : 5'b10000;
`endif
         end
         5: l = 5'b11010;
         default: l = 5'b10010;
      endcase
      return l;
   endfunction

   task automatic model_step(input bit rst, input logic [NREQ-1:0] st);
      bit req;
      bit adv;
      req = |st;
      if (rst) begin
         m_ph = 0; m_t = 0; m_pend = 1'b0;
      end else begin
         if (m_ph == 0) adv = (m_t >= T_GREEN_MIN - 1) && (m_pend || req);
         else           adv = (m_t >= dur(m_ph) - 1);
         if (adv) begin
            m_ph = (m_ph == 5) ? 0 : m_ph + 1;
            m_t  = 0;
            if (m_ph == 3)  m_pend = 1'b0;
            else if (req)   m_pend = 1'b1;
         end else begin
            if (m_t < 1000) m_t = m_t + 1;
            if (req) m_pend = 1'b1;
         end
      end
   endtask

   task automatic step(input bit rst, input logic [NREQ-1:0] st);
      reset = rst;
      start = st;
      model_step(rst, st);
      exp_q.push_back({3'(m_ph), lamps(m_ph, m_t), m_pend});
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0);
   endtask

   // monitor: one expected record per clock edge
   initial begin
      logic [8:0] e;
      forever begin
         @(posedge clock);
         #1;
         cyc++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (phase !== e[8:6]) begin
               miscompares++;
               $display("FAIL phase cyc=%0d got %0d expected %0d", cyc, phase, e[8:6]);
            end
            vectors++;
            if (lightseq !== e[5:1]) begin
               miscompares++;
               $display("FAIL lightseq cyc=%0d got %b expected %b", cyc, lightseq, e[5:1]);
            end
            vectors++;
            if (wait_lamp !== e[0]) begin
               miscompares++;
               $display("FAIL wait_lamp cyc=%0d got %b expected %b", cyc, wait_lamp, e[0]);
            end
         end
      end
   end

   initial begin
      int guard;
      @(negedge clock);
      step(1'b1, '0);
      step(1'b1, '0);
      idle(50);

      // single cyclist press two cycles after reset
      step(1'b1, '0);
      idle(1);
      step(1'b0, 2'b01);
      idle(40);

      // both buttons with road-green timer expired: one crossing only
      step(1'b0, 2'b11);
      idle(40);

      // press during WALK is remembered for the next crossing
      step(1'b0, 2'b01);
      guard = 0;
      while (m_ph != 3 && guard < 100) begin idle(1); guard++; end
      step(1'b0, 2'b10);
      idle(50);

      // reset in the second WALK cycle
      step(1'b0, 2'b01);
      guard = 0;
      while (m_ph != 3 && guard < 100) begin idle(1); guard++; end
      idle(1);
      step(1'b1, '0);
      idle(30);

      // randomized traffic with occasional resets
      for (int i = 0; i < 2000; i++) begin
         logic [NREQ-1:0] st;
         st = ($urandom_range(0, 9) == 0) ? NREQ'($urandom) : '0;
         step(($urandom_range(0, 299) == 0), st);
      end
      idle(5);

      @(posedge clock);
      #2;
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
